bnn_argmax_seq: RTL and testbench

Sequential, handshaked argmax stage that sits directly downstream of the BNN classifier cores (e.g. `pendigits_bnn1_bnnpaar`). It consumes the packed per-class popcount score vector and scans it one class per cycle with a single comparator, replacing the combinational argmax tree. It emits the winning class index and its score with a valid/ready handshake. Lowest index wins ties.

---
 rtl/bnn_argmax_seq.sv | 109 ++++++++++
 tb/tb_bnn_argmax_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_argmax_seq.sv
// Sequential argmax over a packed per-class score vector.
// A vector is captured on accept, then scanned one class per cycle with a
// single unsigned comparator. The winning index and score are held in DONE
// until downstream takes them. On a tie the lowest index wins.
module bnn_argmax_seq #(
  parameter int SIZE       = 10,
  parameter int BITS       = 6,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*BITS-1:0]  inx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDEX_BITS-1:0] outimax,
  output logic [BITS-1:0]       outmax
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [INDEX_BITS-1:0] K_LAST = INDEX_BITS'(SIZE - 1);
  localparam logic [INDEX_BITS-1:0] K_ONE  = INDEX_BITS'(1);

  logic [1:0]            state_q, state_d;
  logic [BITS-1:0]       best_q, best_d;
  logic [INDEX_BITS-1:0] bidx_q, bidx_d;
  logic [INDEX_BITS-1:0] k_q, k_d;
  logic [BITS-1:0]       buf_q [SIZE];
  logic [BITS-1:0]       scan_score;
  logic                  accept;

  // Handshake decode: ready depends only on state and reset, never on the
  // upstream valid or downstream ready.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  // Result ports read zero whenever no result is being presented.
  assign outimax   = out_valid ? bidx_q : '0;
  assign outmax    = out_valid ? best_q : '0;

  assign scan_score = buf_q[k_q];

  // Next-state logic for the scan FSM and the running maximum.
  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          best_d  = inx[BITS-1:0];
          bidx_d  = '0;
          k_d     = K_ONE;
          state_d = (SIZE == 1) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        // Strictly greater only, so an equal later score keeps the earlier index.
        if (scan_score > best_q) begin
          best_d = scan_score;
          bidx_d = k_q;
        end
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers; reset discards any in-flight vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      best_q  <= '0;
      bidx_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      k_q     <= k_d;
    end
  end

  // Score buffer: loaded only on accept, so upstream may change inx afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < SIZE; i++) begin
        buf_q[i] <= inx[i*BITS +: BITS];
      end
    end
  end

endmodule

// File: tb/tb_bnn_argmax_seq.sv
// Testbench for bnn_argmax_seq: directed scenarios plus a randomized
// streaming run against a lowest-index-on-tie argmax model.
module tb_bnn_argmax_seq;

  localparam int SIZE       = 10;
  localparam int BITS       = 6;
  localparam int INDEX_BITS = 4;
  localparam int RW         = INDEX_BITS + BITS;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [SIZE*BITS-1:0]  inx;
  logic                  out_valid;
  logic                  out_ready;
  logic [INDEX_BITS-1:0] outimax;
  logic [BITS-1:0]       outmax;

  int checks;
  int errors;
  logic [RW-1:0] exp_q [$];

  bnn_argmax_seq #(.SIZE(SIZE), .BITS(BITS), .INDEX_BITS(INDEX_BITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .inx(inx),
    .out_valid(out_valid), .out_ready(out_ready),
    .outimax(outimax), .outmax(outmax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SIZE*BITS-1:0] pack(input int s [SIZE]);
    logic [SIZE*BITS-1:0] v;
    v = '0;
    for (int k = 0; k < SIZE; k++) v[k*BITS +: BITS] = BITS'(s[k]);
    return v;
  endfunction

  function automatic logic [RW-1:0] ref_argmax(input logic [SIZE*BITS-1:0] v);
    int best;
    int idx;
    best = int'(v[BITS-1:0]);
    idx  = 0;
    for (int k = 1; k < SIZE; k++) begin
      if (int'(v[k*BITS +: BITS]) > best) begin
        best = int'(v[k*BITS +: BITS]);
        idx  = k;
      end
    end
    return {INDEX_BITS'(idx), BITS'(best)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until it is taken; returns just after the accept edge.
  task automatic send(input logic [SIZE*BITS-1:0] v);
    int cnt;
    inx      = v;
    in_valid = 1'b1;
    cnt      = 0;
    while (in_ready !== 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and sample it; optionally consume it.
  task automatic get_result(input bit consume, output logic [INDEX_BITS-1:0] idx,
                            output logic [BITS-1:0] mx, output int cyc, output bit timeout);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    timeout = (out_valid !== 1'b1);
    idx     = outimax;
    mx      = outmax;
    if (consume && !timeout) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required 0", in_ready);
    end
    checks++;
    if ({out_valid, outimax, outmax} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b idx=%0d max=%0d required 0/0/0", out_valid, outimax, outmax);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got=%b required 1", in_ready);
    end
  endtask

  task automatic test_distinct();
    int s [SIZE] = '{3, 7, 1, 40, 12, 0, 39, 5, 8, 2};
    logic [INDEX_BITS-1:0] idx;
    logic [BITS-1:0] mx;
    logic [RW-1:0] e;
    int cyc;
    bit to;
    exp_q.push_back({4'd3, 6'd40});
    send(pack(s));
    get_result(1'b1, idx, mx, cyc, to);
    checks++;
    if (to || cyc != 9) begin
      errors++;
      $display("FAIL distinct_latency got=%0d timeout=%0b required 9", cyc, to);
    end
    e = exp_q.pop_front();
    checks++;
    if ({idx, mx} !== e) begin
      errors++;
      $display("FAIL distinct_result got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
  endtask

  task automatic test_ties();
    int a [SIZE] = '{17, 17, 17, 17, 17, 17, 17, 17, 17, 17};
    int b [SIZE] = '{5, 5, 5, 5, 9, 5, 5, 5, 9, 5};
    logic [INDEX_BITS-1:0] idx;
    logic [BITS-1:0] mx;
    logic [RW-1:0] e;
    int cyc;
    bit to;
    exp_q.push_back({4'd0, 6'd17});
    send(pack(a));
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL ties_all_equal got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
    exp_q.push_back({4'd4, 6'd9});
    send(pack(b));
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL ties_two_nines got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
  endtask

  task automatic test_extremes();
    int a [SIZE] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 63};
    int z [SIZE] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [INDEX_BITS-1:0] idx;
    logic [BITS-1:0] mx;
    logic [RW-1:0] e;
    int cyc;
    bit to;
    exp_q.push_back({4'd9, 6'd63});
    send(pack(a));
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL extreme_last_max got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
    exp_q.push_back({4'd0, 6'd0});
    send(pack(z));
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL extreme_all_zero got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
  endtask

  task automatic test_backpressure();
    int a [SIZE] = '{1, 2, 30, 4, 5, 6, 7, 8, 9, 10};
    int b [SIZE] = '{50, 2, 3, 4, 5, 6, 51, 8, 9, 10};
    logic [INDEX_BITS-1:0] idx;
    logic [BITS-1:0] mx;
    logic [RW-1:0] e;
    int cyc;
    int bad;
    bit to;
    exp_q.push_back({4'd2, 6'd30});
    send(pack(a));
    get_result(1'b0, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL bp_first_result got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
    // Offer a second vector while the result is stalled.
    exp_q.push_back({4'd6, 6'd51});
    inx      = pack(b);
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {outimax, outmax} !== e) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold bad_cycles=%0d required 0 (valid=%b in_ready=%b idx=%0d max=%0d)", bad, out_valid, in_ready, outimax, outmax);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept in_ready=%b required 0", in_ready);
    end
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || cyc != 9 || {idx, mx} !== e) begin
      errors++;
      $display("FAIL bp_second_result got idx=%0d max=%0d lat=%0d required idx=%0d max=%0d lat=9", idx, mx, cyc, e[RW-1:BITS], e[BITS-1:0]);
    end
  endtask

  task automatic test_reset_mid_scan();
    int a [SIZE] = '{1, 2, 63, 4, 5, 6, 7, 8, 9, 10};
    int b [SIZE] = '{1, 2, 3, 4, 5, 6, 7, 10, 9, 8};
    logic [INDEX_BITS-1:0] idx;
    logic [BITS-1:0] mx;
    logic [RW-1:0] e;
    int cyc;
    bit to;
    send(pack(a));
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan_in_ready got=%b required 0", in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, outimax, outmax} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_scan_outputs got valid=%b idx=%0d max=%0d in_ready=%b required 0/0/0/1", out_valid, outimax, outmax, in_ready);
    end
    exp_q.push_back({4'd7, 6'd10});
    send(pack(b));
    get_result(1'b1, idx, mx, cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {idx, mx} !== e) begin
      errors++;
      $display("FAIL rst_scan_next_result got idx=%0d max=%0d required idx=%0d max=%0d", idx, mx, e[RW-1:BITS], e[BITS-1:0]);
    end
  endtask

  task automatic test_streaming();
    localparam int N = 1000;
    int got;
    int cyc;
    int mism;
    mism = 0;
    got  = 0;
    fork
      begin
        for (int n = 0; n < N; n++) begin
          logic [SIZE*BITS-1:0] v;
          int mode;
          int base;
          mode = int'($urandom_range(0, 2));
          base = int'($urandom_range(0, 63));
          for (int k = 0; k < SIZE; k++) begin
            if (mode == 0) v[k*BITS +: BITS] = BITS'($urandom_range(0, 63));
            else if (mode == 1) v[k*BITS +: BITS] = BITS'($urandom_range(0, 3));
            else v[k*BITS +: BITS] = BITS'(base);
          end
          repeat ($urandom_range(0, 2)) tick();
          exp_q.push_back(ref_argmax(v));
          send(v);
        end
      end
      begin
        cyc = 0;
        while (got < N && cyc < 60000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid === 1'b1 && out_ready) begin
            logic [RW-1:0] e;
            if (exp_q.size() == 0) begin
              mism++;
              $display("FAIL stream_spurious idx=%0d max=%0d required no output", outimax, outmax);
            end else begin
              e = exp_q.pop_front();
              if ({outimax, outmax} !== e) begin
                mism++;
                if (mism <= 5)
                  $display("FAIL stream_result n=%0d got idx=%0d max=%0d required idx=%0d max=%0d", got, outimax, outmax, e[RW-1:BITS], e[BITS-1:0]);
              end
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL stream_mismatches got=%0d required 0", mism);
    end
    checks++;
    if (got != N || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count got=%0d pending=%0d required %0d/0", got, exp_q.size(), N);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inx       = '0;
    test_reset();
    test_distinct();
    test_ties();
    test_extremes();
    test_backpressure();
    test_reset_mid_scan();
    test_streaming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
